// File: rtl/mnist_frame_ctrl.sv
// UART-framed MNIST inference sequencer: loads pixels,
// kicks the accelerator, and reports the digit back.
module mnist_frame_ctrl #(
  parameter int          N_PIXELS     = 784,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          BYTE_TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        answer,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        ANSWER,
  output logic              number_valid,
  output logic [4:0]        state_led,
  output logic              err
);

  localparam int TMO_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_PIXELS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(BYTE_TIMEOUT - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    START = 5'b00100,
    WAIT  = 5'b01000,
    SEND  = 5'b10000
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [TMO_W-1:0]  tmo;

  // One-hot encoding doubles as the LED pattern.
  assign state_led = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tmo          <= '0;
      pix_we       <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= '0;
      start        <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      ANSWER       <= '0;
      number_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      pix_we <= 1'b0;
      start  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state        <= LOAD;
            cnt          <= '0;
            tmo          <= '0;
            number_valid <= 1'b0;
            err          <= 1'b0;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            pix_we   <= 1'b1;
            pix_addr <= cnt;
            pix_data <= rx_data;
            tmo      <= '0;
            if (cnt == LAST) state <= START;
            else             cnt   <= cnt + 1'b1;
          end else if (tmo == TMO_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        START: begin
          start <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            ANSWER       <= answer;
            number_valid <= 1'b1;
            tx_valid     <= 1'b1;
            state        <= SEND;
            // Out-of-range digits are reported as 'E'.
            if (answer <= 4'd9) begin
              tx_data <= 8'h30 + {4'h0, answer};
            end else begin
              tx_data <= 8'h45;
              err     <= 1'b1;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// Randomized bench for mnist_frame_ctrl against a
// transaction-level model of the frame protocol.
module tb_mnist_frame_ctrl;

  localparam int         NP   = 4;
  localparam int         AW   = 10;
  localparam int         TMO  = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          done = 1'b0;
  logic [3:0]    answer = '0;
  logic          tx_ready = 1'b0;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;
  logic          start;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [3:0]    ANSWER;
  logic          number_valid;
  logic [4:0]    state_led;
  logic          err;

  mnist_frame_ctrl #(
    .N_PIXELS(NP), .ADDR_W(AW),
    .SYNC_BYTE(SYNC), .BYTE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .start(start),
    .done(done), .answer(answer),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ANSWER(ANSWER),
    .number_valid(number_valid),
    .state_led(state_led), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         addr;
    logic [7:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  wr_q[$];
  int   st_q[$];

  logic [3:0] m_ans = '0;
  logic       m_nv = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] pix_buf [NP];
  string      digits = "0123456789";

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_we) wr_q.push_back('{cyc, int'(pix_addr), pix_data});
    if (start) st_q.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_tx(input logic [3:0] a);
    if (a <= 4'd9) return digits[int'(a)];
    return "E";
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ans"}, ANSWER, m_ans);
    check({tag, "_nv"}, number_valid, m_nv);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic run_frame(input int gap_lo, input int gap_hi,
                           input logic [3:0] ans,
                           input int rdy_wait);
    logic [7:0] txv;
    wr_q.delete();
    st_q.delete();
    send_byte(SYNC);
    m_nv  = 1'b0;
    m_err = 1'b0;
    check("sync_state", state_led, 5'b00010);
    check("sync_nv", number_valid, 0);
    for (int i = 0; i < NP; i++) begin
      idle($urandom_range(gap_hi, gap_lo));
      send_byte(pix_buf[i]);
    end
    for (int k = 0; k < 8 && st_q.size() == 0; k++) idle(1);
    check("start_cnt", st_q.size(), 1);
    check("wr_cnt", wr_q.size(), NP);
    for (int i = 0; i < NP && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i].addr, i);
      check("wr_data", wr_q[i].data, pix_buf[i]);
    end
    if (st_q.size() > 0 && wr_q.size() > 0)
      check("start_lat", st_q[0] - wr_q[$].cyc, 1);
    idle($urandom_range(3, 0));
    send_byte(SYNC);
    check("wait_state", state_led, 5'b01000);
    check("wait_nv", number_valid, m_nv);
    done   = 1'b1;
    answer = ans;
    @(posedge clk);
    #1;
    done   = 1'b0;
    answer = 4'($urandom);
    m_ans  = ans;
    m_nv   = 1'b1;
    if (ans > 4'd9) m_err = 1'b1;
    txv = exp_tx(ans);
    check("send_state", state_led, 5'b10000);
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, txv);
    check_model("send");
    for (int k = 0; k < rdy_wait; k++) begin
      if (k == 0) send_byte(SYNC);
      else idle(1);
      check("tx_hold_v", tx_valid, 1);
      check("tx_hold_d", tx_data, txv);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("tx_drop", tx_valid, 0);
    check("idle_state", state_led, 5'b00001);
    check("start_once", st_q.size(), 1);
    check_model("end");
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, pix_we, 0);
    check({tag, "_addr"}, pix_addr, 0);
    check({tag, "_data"}, pix_data, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_txd"}, tx_data, 0);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_ans"}, ANSWER, 0);
    check({tag, "_nv"}, number_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_led"}, state_led, 5'b00001);
  endtask

  initial begin
    logic [7:0] jb;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b1;
    idle(2);

    done   = 1'b1;
    answer = 4'd3;
    idle(2);
    done = 1'b0;
    check("stray_done_ans", ANSWER, 0);
    check("stray_done_led", state_led, 5'b00001);

    pix_buf = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(0, 0, 4'd7, 10);

    wr_q.delete();
    st_q.delete();
    send_byte(SYNC);
    m_nv  = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    idle(60);
    m_err = 1'b1;
    check("tmo_led", state_led, 5'b00001);
    check("tmo_start", st_q.size(), 0);
    check("tmo_wr", wr_q.size(), 2);
    check_model("tmo");

    send_byte(8'h3C);
    send_byte(8'h00);
    check("junk_led", state_led, 5'b00001);
    check_model("junk");
    pix_buf = '{SYNC, SYNC, SYNC, SYNC};
    run_frame(0, 0, 4'd12, 2);

    for (int i = 0; i < NP; i++) pix_buf[i] = 8'($urandom);
    run_frame(TMO - 1, TMO - 1, 4'd0, 1);

    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(3, 0)) begin
        jb = 8'($urandom);
        if (jb == SYNC) jb = 8'h00;
        send_byte(jb);
      end
      check_model("rnd_pre");
      for (int i = 0; i < NP; i++) pix_buf[i] = 8'($urandom);
      run_frame(0, 10, 4'($urandom), $urandom_range(4, 0));
    end

    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b0;
    #1;
    m_ans = '0;
    m_nv  = 1'b0;
    m_err = 1'b0;
    check_reset("mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    st_q.delete();
    idle(5);
    check("mid_nostart", st_q.size(), 0);
    pix_buf = '{8'h5A, 8'h00, 8'hFF, 8'h80};
    run_frame(0, 3, 4'd9, 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_frame_ctrl.md
Name: mnist_frame_ctrl

Overview:
- Sequences one MNIST inference over the UART link.
- Parses a framed pixel stream from the UART receiver and writes the pixels into the accelerator's image buffer.
- Pulses the accelerator start, waits for its done, latches the classified digit for the seven-segment path, and returns an ASCII result byte to the UART transmitter.
- Sits between the UART rx/tx cores and the inference datapath inside Main, on the divided system clock.

Parameters:
- N_PIXELS, 784, pixel bytes per frame.
- ADDR_W, 10, image-buffer address width; must satisfy 2^ADDR_W >= N_PIXELS.
- SYNC_BYTE, 8'hA5, frame start marker.
- BYTE_TIMEOUT, 200000, max idle cycles between pixel bytes before abort.

Ports:
- clk  in  1  system clock (divided clock domain).
- rst  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- pix_we  out  1  image-buffer write enable.
- pix_addr  out  ADDR_W  image-buffer write address.
- pix_data  out  8  image-buffer write data.
- start  out  1  one-cycle accelerator start pulse.
- done  in  1  accelerator finished; level or pulse, sampled in WAIT only.
- answer  in  4  accelerator result, valid while done=1.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  transmit request.
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready.
- ANSWER  out  4  latched digit for display.
- number_valid  out  1  ANSWER holds a current result.
- state_led  out  5  one-hot state indicator.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async) values:
  - all outputs 0 except state_led=5'b00001 (IDLE);
  - pixel counter, timeout counter and state cleared.
  - Reset mid-frame discards the partial frame; no start is issued.
- States: IDLE, LOAD, START, WAIT, SEND, one-hot on state_led bits 0..4.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> LOAD; pixel count=0; number_valid cleared the next cycle; err cleared.
  - Any other byte is ignored.
- LOAD:
  - Each rx_valid at cycle t gives pix_we=1, pix_addr=count, pix_data=rx_data at t+1 (registered, single-cycle write); count increments.
  - The byte value SYNC_BYTE is an ordinary pixel here, not a resync.
  - Byte number N_PIXELS-1 written -> START.
  - Timeout counter resets on every rx_valid. It reaches BYTE_TIMEOUT -> IDLE, err=1, no start.
- START: start=1 for exactly one cycle, the cycle after the final pix_we; then WAIT.
- WAIT:
  - rx_valid is ignored.
  - First cycle with done=1: latch ANSWER<=answer; number_valid=1 the next cycle; -> SEND.
- SEND:
  - tx_valid=1, tx_data=8'h30+ANSWER when ANSWER<=9.
  - ANSWER>9: tx_data=8'h45 ('E') and err=1.
  - tx_data is held stable until a cycle with tx_valid&tx_ready; tx_valid drops the next cycle; -> IDLE.
  - rx_valid is ignored.
- number_valid and ANSWER persist through IDLE until the next accepted SYNC_BYTE.
- A done asserted outside WAIT has no effect.
- Counter widths: pixel counter ADDR_W bits, never wraps (leaves LOAD at N_PIXELS-1); timeout counter wide enough for BYTE_TIMEOUT.

Test Plan:
- N_PIXELS=4, BYTE_TIMEOUT=50. Send A5,11,22,33,44 -> pix_we writes (0,11),(1,22),(2,33),(3,44); single start one cycle after the last write.
- In WAIT drive done=1, answer=7 -> ANSWER=7, number_valid=1; tx_data=8'h37 with tx_valid; hold tx_ready=0 for 10 cycles -> tx_data stable; tx_ready=1 -> tx_valid falls next cycle, state_led=00001.
- Send A5,01,02 then 60 idle cycles -> err=1, return to IDLE, no start, number_valid unchanged.
- Send 3C,00 in IDLE, then A5,A5,A5,A5,A5 -> first A5 syncs; the next four are written as pixels 0..3 (value A5); start fires.
- answer=4'd12 on done -> tx_data=8'h45, err=1.
- Assert rst low after 2 pixel bytes -> all outputs reset immediately; a new A5 frame completes normally.
